nfc_host_arbiter: RTL and testbench

- Shares the single NAND flash controller host port (buffer access plus command/start/done handshake) between two requesters, e.g. a test-mode engine and the system host.
- A requester acquires ownership, then has exclusive buffer access. It issues one or more commands and releases ownership when finished.
- Round-robin arbitration. The block sequences nfc_start, waits for nfc_done, and returns completion status to the owner.

---
 rtl/nfc_host_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_nfc_host_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nfc_host_arbiter.sv
// Round-robin arbiter sharing one NAND flash controller host port between two requesters.
// Optional NFC_TIMEOUT_EN macro adds a WAIT-state watchdog that forces an error completion.
module nfc_host_arbiter #(
    parameter int DIOWidth       = 16,
    parameter int AddressWidth   = 16,
    parameter int CommandWidth   = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                req_valid,
    input  logic [1:0]                req_start,
    input  logic [2*CommandWidth-1:0] req_cmd,
    input  logic [2*AddressWidth-1:0] req_addr,
    input  logic [2*DIOWidth-1:0]     req_buf_in,
    input  logic [1:0]                req_buf_sel,
    input  logic [1:0]                req_buf_we,
    input  logic [1:0]                req_buf_re,
    output logic [1:0]                grant,
    output logic [DIOWidth-1:0]       req_buf_out,
    output logic [1:0]                rsp_valid,
    output logic                      rsp_error,
    output logic                      busy,
    output logic                      timeout,
    output logic [CommandWidth-1:0]   nfc_cmd,
    output logic [AddressWidth-1:0]   RWA,
    output logic                      nfc_start,
    output logic [DIOWidth-1:0]       buf_in,
    output logic                      buf_sel,
    output logic                      buf_we,
    output logic                      buf_re,
    input  logic [DIOWidth-1:0]       buf_out,
    input  logic                      nfc_done,
    input  logic                      command_error
);

    typedef enum logic [2:0] {
        IDLE,
        OWNED,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t                    state, state_nxt;
    logic                      owner, owner_nxt;
    logic                      last_owner, last_owner_nxt;
    logic [1:0]                grant_nxt;
    logic [CommandWidth-1:0]   cmd_q, cmd_nxt;
    logic [AddressWidth-1:0]   addr_q, addr_nxt;
    logic                      err_q, err_nxt;

`ifdef NFC_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] wd_cnt, wd_cnt_nxt;
    logic          tmo_q, tmo_nxt;
`endif

    // last_owner resets to 1 so that requester 0 wins the first contention
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            grant      <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            err_q      <= 1'b0;
`ifdef NFC_TIMEOUT_EN
            wd_cnt     <= '0;
            tmo_q      <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            grant      <= grant_nxt;
            cmd_q      <= cmd_nxt;
            addr_q     <= addr_nxt;
            err_q      <= err_nxt;
`ifdef NFC_TIMEOUT_EN
            wd_cnt     <= wd_cnt_nxt;
            tmo_q      <= tmo_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        grant_nxt      = grant;
        cmd_nxt        = cmd_q;
        addr_nxt       = addr_q;
        err_nxt        = err_q;
`ifdef NFC_TIMEOUT_EN
        wd_cnt_nxt     = wd_cnt;
        tmo_nxt        = tmo_q;
`endif
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    if (req_valid == 2'b11) begin
                        owner_nxt = ~last_owner;
                    end else begin
                        owner_nxt = req_valid[1];
                    end
                    grant_nxt = owner_nxt ? 2'b10 : 2'b01;
                    state_nxt = OWNED;
                end
            end
            OWNED: begin
                if (req_start[owner]) begin
                    cmd_nxt   = req_cmd[owner*CommandWidth +: CommandWidth];
                    addr_nxt  = req_addr[owner*AddressWidth +: AddressWidth];
                    state_nxt = ISSUE;
                end else if (!req_valid[owner]) begin
                    grant_nxt      = '0;
                    last_owner_nxt = owner;
                    state_nxt      = IDLE;
                end
            end
            ISSUE: begin
                err_nxt   = 1'b0;
`ifdef NFC_TIMEOUT_EN
                wd_cnt_nxt = '0;
                tmo_nxt    = 1'b0;
`endif
                state_nxt = WAIT;
            end
            WAIT: begin
                if (nfc_done) begin
                    err_nxt   = command_error;
                    state_nxt = RESP;
                end
`ifdef NFC_TIMEOUT_EN
                else if (wd_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_nxt   = 1'b1;
                    tmo_nxt   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    wd_cnt_nxt = wd_cnt + 1'b1;
                end
`endif
            end
            RESP: begin
                state_nxt = OWNED;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign nfc_start   = (state == ISSUE);
    assign busy        = (state == ISSUE) || (state == WAIT) || (state == RESP);
    assign rsp_valid   = (state == RESP) ? grant : 2'b00;
    assign rsp_error   = (state == RESP) && err_q;
    assign nfc_cmd     = cmd_q;
    assign RWA         = addr_q;
    assign req_buf_out = buf_out;

`ifdef NFC_TIMEOUT_EN
    assign timeout = (state == RESP) && tmo_q;
`else
    assign timeout = 1'b0;
`endif

    // Buffer mux follows the registered grant, so it is quiet whenever the port is free
    always_comb begin
        buf_in  = '0;
        buf_sel = 1'b0;
        buf_we  = 1'b0;
        buf_re  = 1'b0;
        if (grant[0]) begin
            buf_in  = req_buf_in[0 +: DIOWidth];
            buf_sel = req_buf_sel[0];
            buf_we  = req_buf_we[0];
            buf_re  = req_buf_re[0];
        end else if (grant[1]) begin
            buf_in  = req_buf_in[DIOWidth +: DIOWidth];
            buf_sel = req_buf_sel[1];
            buf_we  = req_buf_we[1];
            buf_re  = req_buf_re[1];
        end
    end

endmodule

// File: tb/tb_nfc_host_arbiter.sv
// Directed self-checking bench for nfc_host_arbiter.
// With NFC_TIMEOUT_EN defined, the watchdog path is exercised with TIMEOUT_CYCLES=8.
module tb_nfc_host_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_start;
    logic [5:0]  req_cmd;
    logic [31:0] req_addr, req_buf_in;
    logic [1:0]  req_buf_sel, req_buf_we, req_buf_re;
    logic [1:0]  grant, rsp_valid;
    logic [15:0] req_buf_out, RWA, buf_in, buf_out;
    logic        rsp_error, busy, timeout, nfc_start;
    logic [2:0]  nfc_cmd;
    logic        buf_sel, buf_we, buf_re, nfc_done, command_error;

    int total = 0;
    int bad   = 0;

    nfc_host_arbiter #(
        .DIOWidth      (16),
        .AddressWidth  (16),
        .CommandWidth  (3),
`ifdef NFC_TIMEOUT_EN
        .TIMEOUT_CYCLES(8)
`else
        .TIMEOUT_CYCLES(4096)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_start    (req_start),
        .req_cmd      (req_cmd),
        .req_addr     (req_addr),
        .req_buf_in   (req_buf_in),
        .req_buf_sel  (req_buf_sel),
        .req_buf_we   (req_buf_we),
        .req_buf_re   (req_buf_re),
        .grant        (grant),
        .req_buf_out  (req_buf_out),
        .rsp_valid    (rsp_valid),
        .rsp_error    (rsp_error),
        .busy         (busy),
        .timeout      (timeout),
        .nfc_cmd      (nfc_cmd),
        .RWA          (RWA),
        .nfc_start    (nfc_start),
        .buf_in       (buf_in),
        .buf_sel      (buf_sel),
        .buf_we       (buf_we),
        .buf_re       (buf_re),
        .buf_out      (buf_out),
        .nfc_done     (nfc_done),
        .command_error(command_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1ns after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".grant"}, 32'(grant), 32'h0);
        check({tag, ".nfc_start"}, 32'(nfc_start), 32'h0);
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, ".rsp_error"}, 32'(rsp_error), 32'h0);
        check({tag, ".busy"}, 32'(busy), 32'h0);
        check({tag, ".timeout"}, 32'(timeout), 32'h0);
        check({tag, ".nfc_cmd"}, 32'(nfc_cmd), 32'h0);
        check({tag, ".RWA"}, 32'(RWA), 32'h0);
        check({tag, ".buf_in"}, 32'(buf_in), 32'h0);
        check({tag, ".buf_ctl"}, 32'({buf_sel, buf_we, buf_re}), 32'h0);
    endtask

    initial begin
        reset = 1'b0;
        req_valid = '0; req_start = '0; req_cmd = '0; req_addr = '0;
        req_buf_in = '0; req_buf_sel = '0; req_buf_we = '0; req_buf_re = '0;
        buf_out = '0; nfc_done = 1'b0; command_error = 1'b0;

        // Reset values
        tick();
        check_quiet("rst");
        reset = 1'b1;
        tick();

        // Single requester, basic command
        req_valid = 2'b01;
        tick();
        check("r0.grant", 32'(grant), 32'h1);
        check("r0.busy_owned", 32'(busy), 32'h0);
        req_start = 2'b01;
        req_cmd   = 6'b000_010;
        req_addr  = 32'h0000_1234;
        tick();
        req_start = 2'b00;
        check("r0.nfc_start", 32'(nfc_start), 32'h1);
        check("r0.nfc_cmd", 32'(nfc_cmd), 32'h2);
        check("r0.RWA", 32'(RWA), 32'h1234);
        check("r0.busy_issue", 32'(busy), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("r0.wait_start", 32'(nfc_start), 32'h0);
            check("r0.wait_rsp", 32'(rsp_valid), 32'h0);
        end
        nfc_done = 1'b1;
        command_error = 1'b0;
        tick();
        nfc_done = 1'b0;
        check("r0.rsp_valid", 32'(rsp_valid), 32'h1);
        check("r0.rsp_error", 32'(rsp_error), 32'h0);
        check("r0.busy_resp", 32'(busy), 32'h1);
        tick();
        check("r0.rsp_once", 32'(rsp_valid), 32'h0);
        check("r0.busy_back", 32'(busy), 32'h0);
        check("r0.grant_kept", 32'(grant), 32'h1);

        // Spurious nfc_done while OWNED is ignored
        nfc_done = 1'b1;
        tick();
        nfc_done = 1'b0;
        check("ign.done_rsp", 32'(rsp_valid), 32'h0);
        check("ign.done_busy", 32'(busy), 32'h0);
        check("ign.done_start", 32'(nfc_start), 32'h0);

        // Error path; r1 strobe and request during r0's WAIT are ignored
        req_start = 2'b01;
        req_cmd   = 6'b000_101;
        req_addr  = 32'h0000_BEEF;
        tick();
        req_start = 2'b00;
        check("err.nfc_cmd", 32'(nfc_cmd), 32'h5);
        tick();
        req_valid = 2'b11;
        req_start = 2'b10;
        req_cmd   = 6'b111_101;
        tick();
        req_start = 2'b00;
        check("ign.r1_start", 32'(nfc_start), 32'h0);
        check("ign.r1_busy", 32'(busy), 32'h1);
        check("ign.r1_grant", 32'(grant), 32'h1);
        check("ign.r1_cmd", 32'(nfc_cmd), 32'h5);
        tick();
        check("ign.still_wait", 32'(busy), 32'h1);
        nfc_done = 1'b1;
        command_error = 1'b1;
        tick();
        nfc_done = 1'b0;
        command_error = 1'b0;
        check("err.rsp_valid", 32'(rsp_valid), 32'h1);
        check("err.rsp_error", 32'(rsp_error), 32'h1);
        tick();
        check("err.error_gone", 32'(rsp_error), 32'h0);

        // Second command in the same ownership; r0 drops req_valid during WAIT
        req_start = 2'b01;
        req_cmd   = 6'b000_001;
        req_addr  = 32'h0000_0042;
        tick();
        req_start = 2'b00;
        tick();
        req_valid = 2'b10;
        nfc_done = 1'b1;
        tick();
        nfc_done = 1'b0;
        check("cmd2.rsp_valid", 32'(rsp_valid), 32'h1);
        check("cmd2.rsp_error", 32'(rsp_error), 32'h0);
        check("cmd2.RWA", 32'(RWA), 32'h0042);
        tick();
        check("drop.grant_owned", 32'(grant), 32'h1);
        tick();
        check("drop.grant_free", 32'(grant), 32'h0);
        check("drop.cmd_kept", 32'(nfc_cmd), 32'h1);
        check("drop.RWA_kept", 32'(RWA), 32'h0042);
        tick();
        check("r1.grant", 32'(grant), 32'h2);

        // Buffer mux while r1 owns
        req_buf_we  = 2'b11;
        req_buf_sel = 2'b01;
        req_buf_re  = 2'b10;
        req_buf_in  = 32'h5555_AAAA;
        buf_out     = 16'h1357;
        #1;
        check("mux.buf_we", 32'(buf_we), 32'h1);
        check("mux.buf_in", 32'(buf_in), 32'h5555);
        check("mux.buf_sel", 32'(buf_sel), 32'h0);
        check("mux.buf_re", 32'(buf_re), 32'h1);
        check("mux.buf_out", 32'(req_buf_out), 32'h1357);
        req_valid = 2'b00;
        tick();
        check("mux.rel_grant", 32'(grant), 32'h0);
        check("mux.rel_we", 32'(buf_we), 32'h0);
        check("mux.rel_in", 32'(buf_in), 32'h0);
        check("mux.rel_re", 32'(buf_re), 32'h0);

        // Round robin: last owner was r1
        req_valid = 2'b11;
        tick();
        check("rr.first", 32'(grant), 32'h1);
        check("mux.r0_in", 32'(buf_in), 32'hAAAA);
        req_valid = 2'b10;
        tick();
        check("rr.rel0", 32'(grant), 32'h0);
        tick();
        check("rr.second", 32'(grant), 32'h2);
        req_valid = 2'b00;
        tick();
        req_valid = 2'b11;
        tick();
        check("rr.third", 32'(grant), 32'h1);
        req_valid = 2'b10;
        tick();
        tick();
        check("rr.r1_again", 32'(grant), 32'h2);

        // Reset mid-WAIT while r1 owns (last owner is r0 here)
        req_start = 2'b10;
        req_cmd   = 6'b110_000;
        req_addr  = 32'h0F0F_0000;
        tick();
        req_start = 2'b00;
        check("rst.r1_cmd", 32'(nfc_cmd), 32'h6);
        check("rst.r1_RWA", 32'(RWA), 32'h0F0F);
        tick();
        check("rst.in_wait", 32'(busy), 32'h1);
        req_valid = 2'b11;
        reset = 1'b0;
        #1;
        check_quiet("rst.async");
        tick();
        check_quiet("rst.held");
        reset = 1'b1;
        tick();
        check("rst.rr_reset", 32'(grant), 32'h1);
        check("rst.no_start", 32'(nfc_start), 32'h0);
        check("rst.no_busy", 32'(busy), 32'h0);

`ifdef NFC_TIMEOUT_EN
        // Watchdog: no nfc_done, terminal count at WAIT entry + 8
        req_start = 2'b01;
        tick();
        req_start = 2'b00;
        tick();
        for (int i = 1; i < 8; i++) begin
            tick();
            check("tmo.pending", 32'({rsp_valid, timeout}), 32'h0);
        end
        tick();
        check("tmo.rsp_valid", 32'(rsp_valid), 32'h1);
        check("tmo.rsp_error", 32'(rsp_error), 32'h1);
        check("tmo.timeout", 32'(timeout), 32'h1);
        tick();
        check("tmo.pulse_once", 32'(timeout), 32'h0);
`else
        tick();
        check("tmo.tied_low", 32'(timeout), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
